// File: rtl/mem_if_pkg.sv
// Shared definitions for the MEM-stage load/store interface.
// State encoding, word width and access-type constants.
package mem_if_pkg;

  localparam int WORD_W = 16;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam logic MEM_LOAD  = 1'b0;
  localparam logic MEM_STORE = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_WAIT = S_WAIT,
    ST_RESP = S_RESP
  } state_e;

endpackage

// File: rtl/data_mem_responder_ram.sv
// DEPTH x WORD_W word array for the data responder.
// Synchronous write, registered read (read-before-write).
module data_word_ram
  import mem_if_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];

  // write on we, always refresh the read register
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/data_mem_responder.sv
// Responder end of the MEM-stage load/store handshake.
// One outstanding request, fixed latency, range-checked access.
module data_mem_responder
  import mem_if_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [WORD_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              busy
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

  if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
    $error("LATENCY must be in 1..15");
  end

  if (ADDR_W < AW) begin : g_bad_addr_w
    $error("ADDR_W too narrow for DEPTH");
  end

  state_e state;
  state_e state_nx;

  logic [3:0]        cnt;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [WORD_W-1:0] wdata_q;
  logic              err_q;
  logic              rd_ok_q;

  logic              accept;
  logic              commit;
  logic              retire;
  logic              in_rng;
  logic              ram_we;
  logic [WORD_W-1:0] ram_rdata;

  assign accept = req_valid && req_ready;
  assign commit = (state == ST_WAIT) && (cnt == 4'd0);
  assign retire = resp_valid && resp_ready;
  assign in_rng = {1'b0, addr_q} < DEPTH_X;
  assign ram_we = commit && (we_q == MEM_STORE)
                  && in_rng && !rst;

  data_word_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (addr_q[AW-1:0]),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // next state and handshake outputs
  always_comb begin
    state_nx   = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    busy       = 1'b1;
    unique case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) begin
          state_nx = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt == 4'd0) begin
          state_nx = ST_RESP;
        end
      end
      ST_RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          state_nx = ST_IDLE;
        end
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  // request latch and latency counter
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= 4'd0;
      we_q    <= MEM_LOAD;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      cnt     <= LAT_M1;
      we_q    <= req_we;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end else if (state == ST_WAIT && cnt != 4'd0) begin
      cnt <= cnt - 4'd1;
    end
  end

  // response flags, set at commit, cleared at retire
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q   <= 1'b0;
      rd_ok_q <= 1'b0;
    end else if (commit) begin
      err_q   <= !in_rng;
      rd_ok_q <= (we_q == MEM_LOAD) && in_rng;
    end else if (retire) begin
      err_q   <= 1'b0;
      rd_ok_q <= 1'b0;
    end
  end

  // ram read register holds the committed word through RESP
  assign resp_rdata = rd_ok_q ? ram_rdata : '0;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: LATENCY=2 and LATENCY=1 instances.
// Table vectors plus hand sequences, scoreboard queue of responses.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_we     [2];
  logic [15:0] req_addr   [2];
  logic [15:0] req_wdata  [2];
  logic        resp_valid [2];
  logic        resp_ready [2];
  logic [15:0] resp_rdata [2];
  logic        resp_err   [2];
  logic        busy       [2];

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t tbl[11];

  always #5 clk = ~clk;

  data_mem_responder #(
    .ADDR_W(16), .DEPTH(256), .LATENCY(2)
  ) dut_a (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid[0]),
    .req_ready  (req_ready[0]),
    .req_we     (req_we[0]),
    .req_addr   (req_addr[0]),
    .req_wdata  (req_wdata[0]),
    .resp_valid (resp_valid[0]),
    .resp_ready (resp_ready[0]),
    .resp_rdata (resp_rdata[0]),
    .resp_err   (resp_err[0]),
    .busy       (busy[0])
  );

  data_mem_responder #(
    .ADDR_W(16), .DEPTH(256), .LATENCY(1)
  ) dut_b (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid[1]),
    .req_ready  (req_ready[1]),
    .req_we     (req_we[1]),
    .req_addr   (req_addr[1]),
    .req_wdata  (req_wdata[1]),
    .resp_valid (resp_valid[1]),
    .resp_ready (resp_ready[1]),
    .resp_rdata (resp_rdata[1]),
    .resp_err   (resp_err[1]),
    .busy       (busy[1])
  );

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_idle(input int i, input string name);
    chk(name, {12'h0, resp_valid[i], resp_err[i],
               req_ready[i], busy[i], resp_rdata[i]},
        {12'h0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0});
  endtask

  task automatic pop_cmp(input int i, input string name);
    exp_t e;
    if (sb.size() == 0) begin
      chk({name, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({name, "_rdata"}, {16'h0, resp_rdata[i]}, {16'h0, e.rdata});
      chk({name, "_err"}, {31'h0, resp_err[i]}, {31'h0, e.err});
    end
  endtask

  // one full transaction with resp_ready held high
  task automatic txn(input int i, input string name,
                     input logic we, input logic [15:0] ad,
                     input logic [15:0] wd, input logic [15:0] er,
                     input logic ee, input int lat);
    int n;
    int bc;
    exp_t e;
    req_we[i]     = we;
    req_addr[i]   = ad;
    req_wdata[i]  = wd;
    req_valid[i]  = 1'b1;
    resp_ready[i] = 1'b1;
    n = 0;
    while (!req_ready[i] && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({name, "_accept_wait"}, 32'(n), 32'd0);
    if (!req_ready[i]) begin
      req_valid[i] = 1'b0;
      return;
    end
    e.rdata = er;
    e.err   = ee;
    sb.push_back(e);
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
    n  = 0;
    bc = 0;
    while (!resp_valid[i] && n < 40) begin
      if (busy[i]) bc++;
      @(posedge clk); #1;
      n++;
    end
    chk({name, "_latency"}, 32'(n), 32'(lat));
    if (!resp_valid[i]) begin
      void'(sb.pop_front());
      return;
    end
    if (busy[i]) bc++;
    chk({name, "_busy_cycles"}, 32'(bc), 32'(lat + 1));
    pop_cmp(i, name);
    @(posedge clk); #1;
    chk_idle(i, {name, "_retired"});
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [15:0] d0;
    logic        e0;
    exp_t e;

    tbl[0]  = '{1'b1, 16'd5,   16'hBEEF, 16'h0000, 1'b0};
    tbl[1]  = '{1'b0, 16'd5,   16'h0000, 16'hBEEF, 1'b0};
    tbl[2]  = '{1'b1, 16'd10,  16'h1234, 16'h0000, 1'b0};
    tbl[3]  = '{1'b0, 16'd10,  16'h0000, 16'h1234, 1'b0};
    tbl[4]  = '{1'b1, 16'd44,  16'h4444, 16'h0000, 1'b0};
    tbl[5]  = '{1'b0, 16'd300, 16'h0000, 16'h0000, 1'b1};
    tbl[6]  = '{1'b1, 16'd300, 16'h5555, 16'h0000, 1'b1};
    tbl[7]  = '{1'b0, 16'd44,  16'h0000, 16'h4444, 1'b0};
    tbl[8]  = '{1'b1, 16'd255, 16'hFFFF, 16'h0000, 1'b0};
    tbl[9]  = '{1'b0, 16'd255, 16'h0000, 16'hFFFF, 1'b0};
    tbl[10] = '{1'b0, 16'd256, 16'h0000, 16'h0000, 1'b1};

    for (int i = 0; i < 2; i++) begin
      req_valid[i]  = 1'b0;
      req_we[i]     = 1'b0;
      req_addr[i]   = 16'h0;
      req_wdata[i]  = 16'h0;
      resp_ready[i] = 1'b1;
    end
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    chk_idle(0, "reset_a");
    chk_idle(1, "reset_b");

    for (int k = 0; k < 11; k++) begin
      txn(0, $sformatf("vec%0d", k), tbl[k].we, tbl[k].addr,
          tbl[k].wdata, tbl[k].exp_rdata, tbl[k].exp_err, 2);
    end

    // backpressure: response held, second request waiting
    req_we[0]     = 1'b0;
    req_addr[0]   = 16'd5;
    req_valid[0]  = 1'b1;
    resp_ready[0] = 1'b0;
    chk("bp_ready0", {31'h0, req_ready[0]}, 32'd1);
    e.rdata = 16'hBEEF;
    e.err   = 1'b0;
    sb.push_back(e);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    n = 0;
    while (!resp_valid[0] && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("bp_latency", 32'(n), 32'd2);
    d0 = resp_rdata[0];
    e0 = resp_err[0];
    pop_cmp(0, "bp_first");
    req_we[0]    = 1'b0;
    req_addr[0]  = 16'd10;
    req_valid[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk($sformatf("bp_hold%0d", k),
          {13'h0, resp_valid[0], resp_err[0], req_ready[0],
           resp_rdata[0]},
          {13'h0, 1'b1, e0, 1'b0, d0});
    end
    resp_ready[0] = 1'b1;
    @(posedge clk); #1;
    chk("bp_retire", {30'h0, resp_valid[0], req_ready[0]},
        {30'h0, 1'b0, 1'b1});
    e.rdata = 16'h1234;
    e.err   = 1'b0;
    sb.push_back(e);
    @(posedge clk); #1;
    chk("bp_second_accept", {30'h0, busy[0], req_ready[0]},
        {30'h0, 1'b1, 1'b0});
    req_valid[0] = 1'b0;
    n = 0;
    while (!resp_valid[0] && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("bp_second_latency", 32'(n), 32'd2);
    pop_cmp(0, "bp_second");
    @(posedge clk); #1;
    chk_idle(0, "bp_second_retired");

    // reset during WAIT abandons a store
    txn(0, "rst_pre", 1'b1, 16'd7, 16'h7777, 16'h0, 1'b0, 2);
    req_we[0]    = 1'b1;
    req_addr[0]  = 16'd7;
    req_wdata[0] = 16'hAAAA;
    req_valid[0] = 1'b1;
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    chk("rst_in_wait", {30'h0, busy[0], resp_valid[0]},
        {30'h0, 1'b1, 1'b0});
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_idle(0, "rst_mid_wait");
    txn(0, "rst_post_load", 1'b0, 16'd7, 16'h0, 16'h7777, 1'b0, 2);

    // LATENCY=1 instance
    txn(1, "l1_store", 1'b1, 16'd0, 16'h00FF, 16'h0, 1'b0, 1);
    txn(1, "l1_load", 1'b0, 16'd0, 16'h0, 16'h00FF, 1'b0, 1);
    txn(1, "l1_oor", 1'b0, 16'd400, 16'h0, 16'h0, 1'b1, 1);

    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder end of the MEM-stage load/store interface. The pipeline's MEM stage is the initiator.
- Accepts one 16-bit word request at a time over a valid/ready handshake.
- Models a fixed multi-cycle access latency, performs the read or write on an internal word array, and returns a response over a second valid/ready handshake.
- Sits between the MEM stage and data storage. Its request-pending status drives pipeline stall.

Parameters:
- ADDR_W, 16, width of the word address bus.
- DEPTH, 256, number of 16-bit words stored; legal addresses are 0..DEPTH-1.
- LATENCY, 2, cycles from request acceptance to response valid (1..15).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  initiator presents a request.
- req_ready  out  1  responder can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  16  store data.
- resp_valid  out  1  response available.
- resp_ready  in  1  initiator consumes the response this cycle.
- resp_rdata  out  16  load data; 0 for stores and for errors.
- resp_err  out  1  address was out of range (>= DEPTH).
- busy  out  1  a request is accepted and not yet retired; used as the stall source.

Behaviour:
- Reset (rst sampled high at a clk edge):
  - State returns to IDLE.
  - Outputs: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, busy=0; latency counter cleared.
  - Array contents are not cleared.
  - A reset mid-access abandons that access. A pending store that has not yet reached its commit edge is not written.
- State machine: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1, busy=0.
  - On req_valid&&req_ready, latch we/addr/wdata, load counter with LATENCY-1 and go to WAIT.
- WAIT:
  - req_ready=0, busy=1.
  - Counter decrements each cycle.
  - The access commits on the edge where the counter reaches 0. Store: array[addr] <= wdata if in range. Load: resp_rdata <= array[addr].
  - On that same edge go to RESP with resp_valid=1.
  - With LATENCY=1, WAIT lasts exactly one cycle: a request accepted at edge N gives resp_valid=1 after edge N+1.
  - In general resp_valid asserts LATENCY cycles after the accepting edge.
- RESP:
  - resp_valid=1, busy=1, req_ready=0.
  - resp_rdata and resp_err stay stable until the handshake completes.
  - On resp_valid&&resp_ready: resp_valid=0, resp_rdata=0, resp_err=0 on the next edge, and return to IDLE.
  - No back-to-back overlap: a new request can be accepted only from the cycle after the response retires. Single outstanding request.
- Out-of-range address (addr >= DEPTH):
  - No array write.
  - resp_rdata=0, resp_err=1.
  - Same latency as a normal access.
- Store response: resp_rdata=0, resp_err=0 unless out of range.
- Requests while req_ready=0 are ignored. The initiator must hold req_valid and its payload until the handshake completes.
- Read-after-write to the same address in consecutive transactions returns the new data, because the write commits before RESP.
- LATENCY outside 1..15 is a build-time error.

Decomposition:
- Shared package mem_if_pkg:
  - state encoding localparams S_IDLE=2'd0, S_WAIT=2'd1, S_RESP=2'd2;
  - word width constant WORD_W=16;
  - access-type constants MEM_LOAD=1'b0, MEM_STORE=1'b1.
- One sub-module, data_word_ram: DEPTH x 16 synchronous array with port we, addr, wdata, rdata (registered read).
  - The responder owns the FSM, the latency counter, range check and response registers.

Test Plan:
- Reset, then load from addr 5 after a prior store of 16'hBEEF, with LATENCY=2 and resp_ready=1: resp_valid rises 2 cycles after acceptance, resp_rdata=16'hBEEF, resp_err=0, and busy=1 for exactly 3 cycles.
- Store 16'h1234 to addr 10, then load addr 10 back-to-back: second request accepted one cycle after the first response retires, and it returns 16'h1234.
- Load from addr 300 with DEPTH=256: resp_err=1, resp_rdata=0, and the array is unchanged (check addr 44 = 300 mod 256 keeps its prior value).
- Backpressure: hold resp_ready=0 for 5 cycles after resp_valid. resp_valid, resp_rdata and resp_err stay stable, and req_ready stays 0 while a second req_valid is held. That request is accepted the cycle after resp_ready goes to 1.
- Assert rst during WAIT of a store of 16'hAAAA to addr 7 (counter not yet 0): outputs go to their reset values next edge, addr 7 keeps its old value, and req_ready=1.
- LATENCY=1 build: store then load of 16'h00FF at addr 0. Each response is valid exactly 1 cycle after acceptance.
